// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response, pipeline control inputs and IF/ID output.
// The master modport is the fetch unit; the slave modport is memory plus pipeline control.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              freeze;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc_plus4;

  modport master (
    output mem_req, mem_addr, if_valid, if_inst, if_pc_plus4,
    input  mem_ready, mem_rdata, freeze, br_taken, br_addr
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_inst, if_pc_plus4,
    output mem_ready, mem_rdata, freeze, br_taken, br_addr
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch requester: fetches words from the PC, holds up to two returned words
// (output register + skid) while decode is frozen, and squashes/redirects on EX branches.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master fetch_bus
);
  typedef enum logic [0:0] {S_FETCH = 1'b0, S_DROP = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_tgt, w_tgt_nxt;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              r_outstanding;
  logic              r_if_valid, w_if_valid_nxt;
  logic [DATA_W-1:0] r_if_inst, w_if_inst_nxt;
  logic [ADDR_W-1:0] r_if_pc4, w_if_pc4_nxt;
  logic              r_skid_v, w_skid_v_nxt;
  logic [DATA_W-1:0] r_skid_inst, w_skid_inst_nxt;
  logic [ADDR_W-1:0] r_skid_pc4, w_skid_pc4_nxt;
  logic              w_mem_req, w_accept, w_consume, w_out_free;

  // An outstanding request is never withdrawn; a new one is only raised when the skid has room.
  assign w_mem_req  = rst & (r_outstanding | ((r_state == S_FETCH) & ~r_skid_v));
  assign w_accept   = w_mem_req & fetch_bus.mem_ready;
  assign w_consume  = r_if_valid & ~fetch_bus.freeze;
  assign w_out_free = ~r_if_valid | w_consume;
  assign w_pc_plus4 = r_pc + ADDR_W'(3'd4);

  assign fetch_bus.mem_req     = w_mem_req;
  assign fetch_bus.mem_addr    = r_pc;
  assign fetch_bus.if_valid    = r_if_valid;
  assign fetch_bus.if_inst     = r_if_inst;
  assign fetch_bus.if_pc_plus4 = r_if_pc4;

  // Next-state, PC, output register and skid update.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_tgt_nxt       = r_tgt;
    w_if_valid_nxt  = r_if_valid;
    w_if_inst_nxt   = r_if_inst;
    w_if_pc4_nxt    = r_if_pc4;
    w_skid_v_nxt    = r_skid_v;
    w_skid_inst_nxt = r_skid_inst;
    w_skid_pc4_nxt  = r_skid_pc4;
    if (fetch_bus.br_taken) begin
      // Flush wins over freeze; an in-flight miss must still complete, so park the target.
      w_if_valid_nxt = 1'b0;
      w_skid_v_nxt   = 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            w_pc_nxt = fetch_bus.br_addr;
          end else if (w_mem_req) begin
            w_tgt_nxt   = fetch_bus.br_addr;
            w_state_nxt = S_DROP;
          end else begin
            w_pc_nxt = fetch_bus.br_addr;
          end
        end
        S_DROP: begin
          if (w_accept) begin
            w_pc_nxt    = fetch_bus.br_addr;
            w_state_nxt = S_FETCH;
          end else begin
            w_tgt_nxt = fetch_bus.br_addr;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            w_pc_nxt = w_pc_plus4;
          end else begin
            w_pc_nxt = r_pc;
          end
          if (w_out_free) begin
            if (r_skid_v) begin
              w_if_valid_nxt = 1'b1;
              w_if_inst_nxt  = r_skid_inst;
              w_if_pc4_nxt   = r_skid_pc4;
              w_skid_v_nxt   = w_accept;
              if (w_accept) begin
                w_skid_inst_nxt = fetch_bus.mem_rdata;
                w_skid_pc4_nxt  = w_pc_plus4;
              end else begin
                w_skid_inst_nxt = r_skid_inst;
              end
            end else if (w_accept) begin
              w_if_valid_nxt = 1'b1;
              w_if_inst_nxt  = fetch_bus.mem_rdata;
              w_if_pc4_nxt   = w_pc_plus4;
            end else begin
              w_if_valid_nxt = 1'b0;
            end
          end else if (w_accept) begin
            w_skid_v_nxt    = 1'b1;
            w_skid_inst_nxt = fetch_bus.mem_rdata;
            w_skid_pc4_nxt  = w_pc_plus4;
          end else begin
            w_skid_v_nxt = r_skid_v;
          end
        end
        S_DROP: begin
          if (w_accept) begin
            w_pc_nxt    = r_tgt;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_tgt         <= {ADDR_W{1'b0}};
      r_outstanding <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_inst     <= {DATA_W{1'b0}};
      r_if_pc4      <= {ADDR_W{1'b0}};
      r_skid_v      <= 1'b0;
      r_skid_inst   <= {DATA_W{1'b0}};
      r_skid_pc4    <= {ADDR_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_tgt         <= w_tgt_nxt;
      r_outstanding <= w_mem_req & ~fetch_bus.mem_ready;
      r_if_valid    <= w_if_valid_nxt;
      r_if_inst     <= w_if_inst_nxt;
      r_if_pc4      <= w_if_pc4_nxt;
      r_skid_v      <= w_skid_v_nxt;
      r_skid_inst   <= w_skid_inst_nxt;
      r_skid_pc4    <= w_skid_pc4_nxt;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed reset/stream/freeze/branch scenarios, then randomized
// traffic, with a program-order scoreboard fed by the branch targets the driver issues.
module tb_inst_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_bus (bus.master)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] br_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Memory model: returns the word at the presented address whenever it is ready.
  always_comb bus.mem_rdata = bus.mem_ready ? mem_word(bus.mem_addr) : (32'hBAD0_0000 | bus.mem_addr);

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rdy, input bit frz, input bit br, input logic [31:0] ba);
    bus.mem_ready = rdy;
    bus.freeze    = frz;
    bus.br_taken  = br;
    bus.br_addr   = ba;
    if (br) br_q.push_back(ba);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
    else t = 32'($urandom_range(0, 255)) << 2;
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk(!bus.mem_req, "rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk(!bus.if_valid, "rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk(bus.if_inst == 32'h0, "rst_if_inst", bus.if_inst, 32'h0);
    chk(bus.if_pc_plus4 == 32'h0, "rst_if_pc_plus4", bus.if_pc_plus4, 32'h0);
    rst = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard state: expected program-order PC and number of buffered live words.
  logic [31:0] exp_pc;
  int          occ, idle, n_cons;
  bit          drop_pend, m_acc, m_cons, m_dlv;
  bit          p_ok, p_req, p_rdy, p_br, p_val, p_frz;
  logic [31:0] p_addr, p_inst;

  initial begin
    exp_pc = 32'h0; occ = 0; idle = 0; n_cons = 0; drop_pend = 1'b0; p_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_pc = 32'h0; occ = 0; idle = 0; drop_pend = 1'b0; p_ok = 1'b0;
        br_q.delete();
      end else begin
        if (p_ok && p_req && !p_rdy)
          chk(bus.mem_req && (bus.mem_addr == p_addr), "req_hold", bus.mem_addr, p_addr);
        if (p_ok && p_br)
          chk(!bus.if_valid, "flush", {31'd0, bus.if_valid}, 32'd0);
        if (p_ok && !p_br && p_val && p_frz)
          chk(bus.if_valid && (bus.if_inst == p_inst), "freeze_hold", bus.if_inst, p_inst);
        chk(bus.if_valid == (occ > 0), "valid_vs_occupancy", {31'd0, bus.if_valid}, (occ > 0) ? 32'd1 : 32'd0);
        if (occ >= 2)
          chk((occ == 2) && !bus.mem_req, "stall_fill", 32'(occ), 32'd2);
        if (bus.mem_req)
          chk(bus.mem_addr[1:0] == 2'b00, "addr_align", bus.mem_addr, {bus.mem_addr[31:2], 2'b00});
        m_acc  = bus.mem_req && bus.mem_ready;
        m_cons = bus.if_valid && !bus.freeze;
        m_dlv  = m_acc && !bus.br_taken && !drop_pend;
        if (m_cons) begin
          chk(bus.if_pc_plus4 == exp_pc + 32'd4, "order_pc_plus4", bus.if_pc_plus4, exp_pc + 32'd4);
          chk(bus.if_inst == mem_word(exp_pc), "order_inst", bus.if_inst, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          n_cons++;
          idle = 0;
        end else begin
          idle++;
        end
        chk(idle < 64, "progress", 32'(idle), 32'd64);
        if (bus.br_taken) begin
          if (br_q.size() == 0) chk(1'b0, "branch_queue", 32'd0, 32'd1);
          else exp_pc = br_q.pop_front();
          occ       = 0;
          drop_pend = bus.mem_req && !bus.mem_ready;
        end else begin
          occ = occ + (m_dlv ? 1 : 0) - (m_cons ? 1 : 0);
          if (m_acc) drop_pend = 1'b0;
        end
        p_ok = 1'b1; p_req = bus.mem_req; p_rdy = bus.mem_ready; p_br = bus.br_taken;
        p_val = bus.if_valid; p_frz = bus.freeze; p_addr = bus.mem_addr; p_inst = bus.if_inst;
      end
    end
  end

  initial begin
    // Reset, then zero-wait streaming from address 0.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk(bus.mem_req, "t1_req_after_release", {31'd0, bus.mem_req}, 32'd1);
    chk(bus.mem_addr == 32'h0, "t1_addr_after_release", bus.mem_addr, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk(bus.if_valid && (bus.if_pc_plus4 == 32'(k * 4)), "t2_pc_plus4", bus.if_pc_plus4, 32'(k * 4));
      chk(bus.if_inst == mem_word(32'((k - 1) * 4)), "t2_inst", bus.if_inst, mem_word(32'((k - 1) * 4)));
    end

    // Freeze held three cycles while streaming.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    nxt(); drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      nxt(); drive(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk(!bus.mem_req, "t3_req_low_full", {31'd0, bus.mem_req}, 32'd0);
      chk(bus.if_inst == mem_word(32'h0), "t3_inst_held", bus.if_inst, mem_word(32'h0));
    end
    nxt(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk(!bus.mem_req, "t3_req_low_draining", {31'd0, bus.mem_req}, 32'd0);
    nxt();
    @(negedge clk);
    chk(bus.if_inst == mem_word(32'h4) && bus.if_pc_plus4 == 32'h8, "t3_after_release", bus.if_pc_plus4, 32'h8);
    nxt();
    @(negedge clk);
    chk(bus.if_inst == mem_word(32'h8) && bus.if_pc_plus4 == 32'hC, "t3_next", bus.if_pc_plus4, 32'hC);

    // Miss at 0x40 with a branch to 0x20 arriving while it is in flight.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      drive((k == 4), 1'b0, (k == 2), 32'h20);
      @(negedge clk);
      chk(bus.mem_req && bus.mem_addr == 32'h40, "t4_addr_held", bus.mem_addr, 32'h40);
      chk(!bus.if_valid, "t4_no_valid", {31'd0, bus.if_valid}, 32'd0);
    end
    for (int k = 5; k <= 6; k++) begin
      nxt();
      drive((k == 6), 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk(bus.mem_req && bus.mem_addr == 32'h20, "t4_redirect_addr", bus.mem_addr, 32'h20);
      chk(!bus.if_valid, "t4_wait_valid", {31'd0, bus.if_valid}, 32'd0);
    end
    nxt();
    @(negedge clk);
    chk(bus.if_valid && bus.if_inst == mem_word(32'h20), "t4_target_inst", bus.if_inst, mem_word(32'h20));

    // Branch, ready and freeze in the same cycle.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) nxt();
    drive(1'b1, 1'b1, 1'b1, 32'h100);
    nxt(); drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk(!bus.if_valid, "t5_flushed", {31'd0, bus.if_valid}, 32'd0);
    chk(bus.mem_req && bus.mem_addr == 32'h100, "t5_target_addr", bus.mem_addr, 32'h100);
    nxt();
    @(negedge clk);
    chk(bus.if_valid && bus.if_pc_plus4 == 32'h104, "t5_target_valid", bus.if_pc_plus4, 32'h104);

    // Asynchronous reset while a redirect is pending behind a miss.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    nxt(); drive(1'b0, 1'b0, 1'b1, 32'h80);
    nxt(); drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk(!bus.mem_req && !bus.if_valid, "t6_async_clear", {31'd0, bus.mem_req}, 32'd0);
    chk(bus.mem_addr == 32'h0, "t6_pc_cleared", bus.mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk(bus.mem_req && bus.mem_addr == 32'h0, "t6_refetch_reset_pc", bus.mem_addr, 32'h0);
    nxt();

    // Randomized traffic: zero-wait, then increasingly slow memory.
    for (int c = 0; c < 1500; c++) begin
      drive(1'b1, ($urandom_range(0, 9) < 3), ($urandom_range(0, 11) == 0), pick_target());
      nxt();
    end
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0), pick_target());
      nxt();
    end
    for (int c = 0; c < 1000; c++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 14) == 0), pick_target());
      nxt();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) nxt();

    chk(n_cons > 300, "consumed_total", 32'(n_cons), 32'd300);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
